// File: rtl/trace_stream_packer.sv
// -----------------------------------------------------------------------------
// trace_stream_packer
//
// Purpose:
//   Captures trace items {pc, instr, cycle delta, overflow flag} from the
//   monitored instruction stream (after trace_filter has decided whether to
//   drop each instruction) into a first-word-fall-through FIFO. The FIFO is
//   drained as an AXI-Stream-style valid/ready stream, with tlast marking
//   every ITEMS_PER_PACKET-th item. Items lost because the FIFO was full are
//   counted, and the next item that does get stored carries an overflow flag.
//
// Ports:
//   clk         in   clock, all state updates on the rising edge
//   rst         in   asynchronous active-high reset
//   en          in   capture enable (0 blocks captures, draining continues)
//   pc_valid    in   pc/instr valid this cycle
//   pc          in   PC of the instruction            [PC_WIDTH]
//   instr       in   instruction word                 [INSTR_WIDTH]
//   drop_instr  in   trace_filter drop decision, same cycle as pc_valid
//   m_tvalid    out  stream item valid
//   m_tready    in   downstream ready
//   m_tdata     out  {pc, instr, delta[30:0], ovf_flag}
//   m_tlast     out  last item of packet
//   fifo_level  out  current FIFO occupancy          [$clog2(FIFO_DEPTH)+1]
//   ovf_count   out  saturating count of lost items  [OVF_COUNT_WIDTH]
// -----------------------------------------------------------------------------
module trace_stream_packer #(
  parameter int PC_WIDTH         = 64,
  parameter int INSTR_WIDTH      = 32,
  parameter int FIFO_DEPTH       = 16,
  parameter int ITEMS_PER_PACKET = 8,
  parameter int OVF_COUNT_WIDTH  = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  logic                                 pc_valid,
  input  logic [PC_WIDTH-1:0]                  pc,
  input  logic [INSTR_WIDTH-1:0]               instr,
  input  logic                                 drop_instr,
  output logic                                 m_tvalid,
  input  logic                                 m_tready,
  output logic [PC_WIDTH+INSTR_WIDTH+32-1:0]   m_tdata,
  output logic                                 m_tlast,
  output logic [$clog2(FIFO_DEPTH):0]          fifo_level,
  output logic [OVF_COUNT_WIDTH-1:0]           ovf_count
);

  localparam int DATA_W  = PC_WIDTH + INSTR_WIDTH + 32;
  localparam int ADDR_W  = $clog2(FIFO_DEPTH);
  localparam int LEVEL_W = ADDR_W + 1;
  // A one-item packet still needs a one-bit counter to keep widths legal.
  localparam int PKT_W   = (ITEMS_PER_PACKET > 1) ? $clog2(ITEMS_PER_PACKET) : 1;

  localparam logic [LEVEL_W-1:0]         LEVEL_FULL = LEVEL_W'(FIFO_DEPTH);
  localparam logic [LEVEL_W-1:0]         LEVEL_ONE  = LEVEL_W'(1);
  localparam logic [ADDR_W-1:0]          PTR_ONE    = ADDR_W'(1);
  localparam logic [PKT_W-1:0]           PKT_LAST   = PKT_W'(ITEMS_PER_PACKET - 1);
  localparam logic [PKT_W-1:0]           PKT_ONE    = PKT_W'(1);
  localparam logic [30:0]                DELTA_MAX  = {31{1'b1}};
  localparam logic [30:0]                DELTA_ONE  = 31'd1;
  localparam logic [OVF_COUNT_WIDTH-1:0] OVF_MAX    = {OVF_COUNT_WIDTH{1'b1}};
  localparam logic [OVF_COUNT_WIDTH-1:0] OVF_ONE    = OVF_COUNT_WIDTH'(1);

  // Storage
  logic [DATA_W-1:0]           mem_data_r [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]       mem_last_r;

  // Control state
  logic [ADDR_W-1:0]           wr_ptr_r;
  logic [ADDR_W-1:0]           rd_ptr_r;
  logic [LEVEL_W-1:0]          level_r;
  logic [LEVEL_W-1:0]          level_next_s;
  logic [PKT_W-1:0]            pkt_cnt_r;
  logic [30:0]                 since_last_r;
  logic                        ovf_pending_r;
  logic [OVF_COUNT_WIDTH-1:0]  ovf_count_r;

  // Handshake decode
  logic                        cap_s;
  logic                        full_s;
  logic                        push_s;
  logic                        pop_s;
  logic                        lost_s;
  logic                        item_last_s;
  logic [DATA_W-1:0]           item_s;

  // Capture/push/pop decode. A pop frees a slot in the same edge, so a full
  // FIFO can still accept a push while the consumer is taking an item.
  always_comb begin
    cap_s       = en & pc_valid & ~drop_instr;
    full_s      = (level_r == LEVEL_FULL);
    pop_s       = m_tvalid & m_tready;
    push_s      = cap_s & (~full_s | pop_s);
    lost_s      = cap_s & ~push_s;
    item_last_s = (pkt_cnt_r == PKT_LAST);
    item_s      = {pc, instr, since_last_r, ovf_pending_r};
  end

  // Occupancy update from the push/pop pair.
  always_comb begin
    level_next_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_next_s = level_r + LEVEL_ONE;
      2'b01:   level_next_s = level_r - LEVEL_ONE;
      default: level_next_s = level_r;
    endcase
  end

  // Item storage. Contents need no reset: an empty FIFO masks the read port.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_data_r[wr_ptr_r] <= item_s;
      mem_last_r[wr_ptr_r] <= item_last_s;
    end
  end

  // Pointers and occupancy. Power-of-two depth makes pointer wrap implicit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      level_r <= level_next_s;
    end
  end

  // Packet position; only stored items advance it, so lost items and
  // en-low gaps leave the packet boundary where it was.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_r <= '0;
    end else if (push_s) begin
      if (item_last_s) begin
        pkt_cnt_r <= '0;
      end else begin
        pkt_cnt_r <= pkt_cnt_r + PKT_ONE;
      end
    end
  end

  // Cycles since the previous capture. Restarts at 1 on every capture,
  // stored or lost, so back-to-back captures report a delta of 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      since_last_r <= '0;
    end else if (cap_s) begin
      since_last_r <= DELTA_ONE;
    end else if (since_last_r != DELTA_MAX) begin
      since_last_r <= since_last_r + DELTA_ONE;
    end
  end

  // Overflow bookkeeping: lost captures are counted (saturating) and flag
  // the next stored item, which consumes the pending flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_pending_r <= 1'b0;
      ovf_count_r   <= '0;
    end else if (push_s) begin
      ovf_pending_r <= 1'b0;
    end else if (lost_s) begin
      ovf_pending_r <= 1'b1;
      if (ovf_count_r != OVF_MAX) begin
        ovf_count_r <= ovf_count_r + OVF_ONE;
      end
    end
  end

  // Stream outputs come straight from registered state, so m_tready has no
  // combinational path to m_tvalid and the head item is stable while stalled.
  always_comb begin
    m_tvalid   = (level_r != '0);
    m_tdata    = m_tvalid ? mem_data_r[rd_ptr_r] : '0;
    m_tlast    = m_tvalid & mem_last_r[rd_ptr_r];
    fifo_level = level_r;
    ovf_count  = ovf_count_r;
  end

endmodule

// File: tb/tb_trace_stream_packer.sv
// -----------------------------------------------------------------------------
// tb_trace_stream_packer
//
// Directed self-checking bench for trace_stream_packer with default
// parameters (PC 64, INSTR 32, depth 16, 8 items per packet). Inputs change
// and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_trace_stream_packer;

  logic         clk;
  logic         rst;
  logic         en;
  logic         pc_valid;
  logic [63:0]  pc;
  logic [31:0]  instr;
  logic         drop_instr;
  logic         m_tvalid;
  logic         m_tready;
  logic [127:0] m_tdata;
  logic         m_tlast;
  logic [4:0]   fifo_level;
  logic [15:0]  ovf_count;

  int checks;
  int errors;

  trace_stream_packer dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pc_valid   (pc_valid),
    .pc         (pc),
    .instr      (instr),
    .drop_instr (drop_instr),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tdata    (m_tdata),
    .m_tlast    (m_tlast),
    .fifo_level (fifo_level),
    .ovf_count  (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word paired with each PC.
  function automatic logic [31:0] instr_of(input logic [63:0] p);
    return p[31:0] ^ 32'hA5A5_0000;
  endfunction

  // Expected stream item.
  function automatic logic [127:0] item(input logic [63:0] p, input logic [30:0] d,
                                        input logic f);
    return {p, instr_of(p), d, f};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] p, input logic drop);
    pc_valid   = v;
    pc         = p;
    instr      = instr_of(p);
    drop_instr = drop;
  endtask

  // Reset pulse; released 1 time unit after an edge so the next edge is the
  // first one out of reset.
  task automatic reset_dut();
    drive(1'b0, 64'd0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    en         = 1'b1;
    m_tready   = 1'b1;
    drive(1'b0, 64'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_tvalid", m_tvalid, 1'b0);
    check("rst_tlast", m_tlast, 1'b0);
    check("rst_tdata", m_tdata, 128'd0);
    check("rst_level", fifo_level, 5'd0);
    check("rst_ovf", ovf_count, 16'd0);
    rst = 1'b0;

    // Three consecutive captures; two idle edges first so first delta is 2
    tick();
    tick();
    drive(1'b1, 64'h1000, 1'b0);
    tick();
    check("t1_beat0", m_tdata, item(64'h1000, 31'd2, 1'b0));
    check("t1_last0", m_tlast, 1'b0);
    drive(1'b1, 64'h1004, 1'b0);
    tick();
    check("t1_beat1", m_tdata, item(64'h1004, 31'd1, 1'b0));
    drive(1'b1, 64'h1008, 1'b0);
    tick();
    check("t1_beat2", m_tdata, item(64'h1008, 31'd1, 1'b0));
    check("t1_last2", m_tlast, 1'b0);
    drive(1'b0, 64'd0, 1'b0);
    tick();
    check("t1_empty", m_tvalid, 1'b0);

    // Dropped middle instruction
    reset_dut();
    drive(1'b1, 64'h2000, 1'b0);
    tick();
    check("t2_beat0", m_tdata, item(64'h2000, 31'd0, 1'b0));
    drive(1'b1, 64'h2004, 1'b1);
    tick();
    check("t2_drop_gap", m_tvalid, 1'b0);
    drive(1'b1, 64'h2008, 1'b0);
    tick();
    check("t2_beat1", m_tdata, item(64'h2008, 31'd2, 1'b0));
    drive(1'b0, 64'd0, 1'b0);
    tick();
    check("t2_empty", m_tvalid, 1'b0);
    check("t2_level", fifo_level, 5'd0);

    // Overflow: 20 captures into a stalled 16-deep FIFO
    reset_dut();
    m_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 64'h3000 + 64'(4 * i), 1'b0);
      tick();
    end
    check("t3_full_level", fifo_level, 5'd16);
    check("t3_ovf", ovf_count, 16'd4);
    check("t3_stall_head", m_tdata, item(64'h3000, 31'd0, 1'b0));
    check("t3_stall_last", m_tlast, 1'b0);
    // Full, draining and capturing in the same cycle
    m_tready = 1'b1;
    drive(1'b1, 64'h3050, 1'b0);
    tick();
    check("t3_fullpush_level", fifo_level, 5'd16);
    check("t3_fullpush_ovf", ovf_count, 16'd4);
    drive(1'b0, 64'd0, 1'b0);
    for (int k = 1; k < 16; k++) begin
      check("t3_drain", m_tdata, item(64'h3000 + 64'(4 * k), 31'd1, 1'b0));
      check("t3_drain_last", m_tlast, (k % 8) == 7);
      tick();
    end
    check("t3_flagged", m_tdata, item(64'h3050, 31'd1, 1'b1));
    check("t3_flagged_last", m_tlast, 1'b0);
    tick();
    check("t3_empty", m_tvalid, 1'b0);

    // tlast every 8 items over 16 captures
    reset_dut();
    m_tready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      drive(1'b1, 64'h4000 + 64'(4 * j), 1'b0);
      tick();
      check("t4_beat", m_tdata, item(64'h4000 + 64'(4 * j), (j == 0) ? 31'd0 : 31'd1, 1'b0));
      check("t4_last", m_tlast, (j % 8) == 7);
    end
    drive(1'b0, 64'd0, 1'b0);
    tick();
    check("t4_empty", m_tvalid, 1'b0);

    // Asynchronous reset mid-stream with 5 items queued
    reset_dut();
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 64'h5000 + 64'(4 * i), 1'b0);
      tick();
    end
    drive(1'b0, 64'd0, 1'b0);
    check("t5_level5", fifo_level, 5'd5);
    rst = 1'b1;
    #1;
    check("t5_async_tvalid", m_tvalid, 1'b0);
    check("t5_async_level", fifo_level, 5'd0);
    check("t5_async_tdata", m_tdata, 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_tready = 1'b1;
    // Post-reset packet with an en-low gap of two cycles after item 3
    for (int k = 0; k < 8; k++) begin
      if (k == 4) begin
        en = 1'b0;
        drive(1'b1, 64'h6FF0, 1'b0);
        tick();
        tick();
        check("t5_en_gap", m_tvalid, 1'b0);
        en = 1'b1;
      end
      drive(1'b1, 64'h6000 + 64'(4 * k), 1'b0);
      tick();
      check("t5_beat", m_tdata,
            item(64'h6000 + 64'(4 * k), (k == 0) ? 31'd0 : ((k == 4) ? 31'd3 : 31'd1), 1'b0));
      check("t5_last", m_tlast, k == 7);
    end
    drive(1'b0, 64'd0, 1'b0);
    tick();
    check("t5_empty", m_tvalid, 1'b0);
    check("t5_ovf", ovf_count, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_stream_packer.md
Name: trace_stream_packer

Overview:
- Sits directly downstream of trace_filter.
- On every cycle where the monitored PC is valid and trace_filter does not drop the instruction, captures a trace item {pc, instr, cycle delta, overflow flag} into an internal FIFO.
- Presents FIFO contents as an AXI-Stream-style valid/ready packet stream toward the DMA, asserting tlast every ITEMS_PER_PACKET items.
- Counts items lost to FIFO overflow and marks the next stored item.

Parameters:
- PC_WIDTH, 64, width of program counter field.
- INSTR_WIDTH, 32, width of instruction field.
- FIFO_DEPTH, 16, number of item entries; power of 2, minimum 2.
- ITEMS_PER_PACKET, 8, items per stream packet; tlast on the final item; minimum 1.
- OVF_COUNT_WIDTH, 16, width of overflow counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  capture enable; 0 blocks new captures, draining continues.
- pc_valid  in  1  pc/instr valid this cycle.
- pc  in  PC_WIDTH  PC of the instruction.
- instr  in  INSTR_WIDTH  instruction word; same instr as fed to trace_filter next_instr.
- drop_instr  in  1  from trace_filter, aligned to the same cycle as pc_valid/instr.
- m_tvalid  out  1  stream item valid.
- m_tready  in  1  downstream ready.
- m_tdata  out  PC_WIDTH+INSTR_WIDTH+32  item: [top:INSTR_WIDTH+32]=pc, [INSTR_WIDTH+31:32]=instr, [31:1]=delta, [0]=ovf_flag.
- m_tlast  out  1  last item of packet.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- ovf_count  out  OVF_COUNT_WIDTH  items lost since reset; saturating.

Behaviour:
- Capture event: cap = en & pc_valid & ~drop_instr, evaluated at the rising edge.
- push = cap & (~full | pop); pop = m_tvalid & m_tready; lost = cap & ~push.
- FIFO is first-word-fall-through; storage is registered.
  - Item captured at edge N shows on m_tdata with m_tvalid=1 from edge N onward (empty FIFO), i.e. visible the cycle after the capture cycle.
  - m_tvalid = (level != 0). m_tdata and m_tlast are stable while m_tvalid & ~m_tready.
- Simultaneous push and pop:
  - When full: push is accepted and level stays at FIFO_DEPTH.
  - When empty: no fall-through bypass; push is stored, pop cannot occur since m_tvalid=0.
- Pointers wrap modulo FIFO_DEPTH. Full is when level==FIFO_DEPTH.
- Delta counter since_last (31 bits):
  - Reset to 0, increments every cycle, saturates at 2^31-1.
  - On any cap (pushed or lost): item delta field = since_last, then since_last <= 1.
  - Back-to-back captures therefore give delta=1.
- Overflow:
  - On lost, ovf_count increments (saturating at all-ones) and sticky ovf_pending is set.
  - The next pushed item has bit0=1 and clears ovf_pending.
  - If lost and push occur in the same cycle (impossible by definition), push has priority; nothing else applies.
- tlast:
  - pkt_cnt counts pushed items, 0..ITEMS_PER_PACKET-1, wrapping.
  - The item pushed when pkt_cnt==ITEMS_PER_PACKET-1 is stored with last=1.
  - The last bit travels with the item; lost items do not advance pkt_cnt.
- en deassertion mid-packet: pkt_cnt holds; the packet continues when en returns.
- Reset (async, any time):
  - m_tvalid=0, m_tlast=0, m_tdata=0, fifo_level=0, ovf_count=0.
  - Pointers, pkt_cnt, ovf_pending and since_last cleared.
  - In-flight FIFO contents are discarded.
- No combinational path from m_tready to m_tvalid.

Test Plan:
- Reset, then 3 consecutive cycles pc_valid=1, drop_instr=0, pc=0x1000/0x1004/0x1008, m_tready=1 -> three beats in order; deltas 0+k (first = cycles since reset release), 1, 1; bit0=0; m_tlast=0.
- drop_instr=1 on the middle of 3 valid cycles -> only 2 beats emitted; second beat delta=2.
- m_tready=0 with 20 back-to-back captures (FIFO_DEPTH=16) -> fifo_level=16, ovf_count=4. Then m_tready=1 and one more capture -> 17th emitted item has bit0=1 and delta=1; earlier 16 have bit0=0.
- 16 captures with m_tready=1, ITEMS_PER_PACKET=8 -> m_tlast=1 exactly on beats 8 and 16.
- Full FIFO, m_tready=1 and capture in the same cycle -> ovf_count unchanged, level stays 16, new item appended.
- Assert rst for 1 cycle mid-stream with level=5 -> m_tvalid=0 immediately (async), level=0. Next packet's tlast lands on the 8th post-reset item.
